// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-requester mux arbiter.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic OWNER_A      = 1'b0;
    localparam logic OWNER_B      = 1'b1;
    localparam int   MAX_HOLD_DEF = 8;

endpackage

// File: rtl/mux_arb_hold_cnt.sv
// Saturating hold counter: counts owned cycles under contention and flags the hand-over limit.
module mux_arb_hold_cnt #(
    parameter int CNT_W    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic clock,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_limit
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_limit) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_limit = (r_cnt == LIMIT);

endmodule

// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter with bounded hold, driving a registered 2:1 data mux.
// Define MUX_ARB_FIXED_PRIO_EN for fixed priority to A (only B is hold-limited).
module mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int CNT_W    = 4
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic              req_b,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              sel,
    output logic [DATA_W-1:0] out,
    output logic              out_valid
);

    state_t            r_state;
    state_t            w_next;
    logic              r_sel;
    logic [DATA_W-1:0] r_out;
    logic              r_out_valid;
    logic              w_limit;
    logic              w_cnt_en;
    logic              w_tie_to_a;
    logic              w_preempt_a;

`ifdef MUX_ARB_FIXED_PRIO_EN
    assign w_tie_to_a  = 1'b1;
    assign w_preempt_a = 1'b0;
`else
    logic r_last_owner;

    assign w_tie_to_a  = (r_last_owner == OWNER_B);
    assign w_preempt_a = w_limit;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_last_owner <= OWNER_B;
        end else if (w_next == OWN_A) begin
            r_last_owner <= OWNER_A;
        end else if (w_next == OWN_B) begin
            r_last_owner <= OWNER_B;
        end
    end
`endif

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_a && req_b) begin
                    w_next = w_tie_to_a ? OWN_A : OWN_B;
                end else if (req_a) begin
                    w_next = OWN_A;
                end else if (req_b) begin
                    w_next = OWN_B;
                end
            end
            OWN_A: begin
                if (!req_a) begin
                    w_next = req_b ? OWN_B : IDLE;
                end else if (req_b && w_preempt_a) begin
                    w_next = OWN_B;
                end
            end
            OWN_B: begin
                if (!req_b) begin
                    w_next = req_a ? OWN_A : IDLE;
                end else if (req_a && w_limit) begin
                    w_next = OWN_A;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // The counter only advances while the non-owner is waiting.
    assign w_cnt_en = ((r_state == OWN_A) && req_b) || ((r_state == OWN_B) && req_a);

    mux_arb_hold_cnt #(
        .CNT_W    (CNT_W),
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_cnt (
        .clock   (clock),
        .rst_n   (rst_n),
        .i_clr   (w_next != r_state),
        .i_en    (w_cnt_en),
        .o_limit (w_limit)
    );

    // Select follows the incoming owner so it is already correct in the first owned cycle.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_sel       <= OWNER_A;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_next == OWN_A) begin
                r_sel <= OWNER_A;
            end else if (w_next == OWN_B) begin
                r_sel <= OWNER_B;
            end
            if (gnt_a || gnt_b) begin
                r_out       <= r_sel ? data_b : data_a;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign gnt_a     = (r_state == OWN_A);
    assign gnt_b     = (r_state == OWN_B);
    assign sel       = r_sel;
    assign out       = r_out;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed self-checking bench for mux_arbiter (default and MAX_HOLD=1 instances).
module tb_mux_arbiter;

    logic       clock;
    logic       rst_n;
    logic       req_a, req_b;
    logic [7:0] data_a, data_b;
    logic       gnt_a, gnt_b, sel, out_valid;
    logic [7:0] out;

    logic       req_a1, req_b1;
    logic [7:0] data_a1, data_b1;
    logic       gnt_a1, gnt_b1, sel1, out_valid1;
    logic [7:0] out1;

    int checks = 0;
    int errors = 0;

    mux_arbiter #(.DATA_W(8), .MAX_HOLD(8), .CNT_W(4)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .req_a     (req_a),
        .req_b     (req_b),
        .data_a    (data_a),
        .data_b    (data_b),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .sel       (sel),
        .out       (out),
        .out_valid (out_valid)
    );

    mux_arbiter #(.DATA_W(8), .MAX_HOLD(1), .CNT_W(1)) dut1 (
        .clock     (clock),
        .rst_n     (rst_n),
        .req_a     (req_a1),
        .req_b     (req_b1),
        .data_a    (data_a1),
        .data_b    (data_b1),
        .gnt_a     (gnt_a1),
        .gnt_b     (gnt_b1),
        .sel       (sel1),
        .out       (out1),
        .out_valid (out_valid1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       ra;
        logic       rb;
        logic [7:0] da;
        logic [7:0] db;
        logic       ga;
        logic       gb;
        logic       sl;
        logic [7:0] ou;
        logic       ov;
    } vec_t;

    localparam int NVEC = 21;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic ra, input logic rb, input logic [7:0] da,
                                input logic [7:0] db, input logic ga, input logic gb,
                                input logic sl, input logic [7:0] ou, input logic ov);
        vec_t v;
        v.ra = ra; v.rb = rb; v.da = da; v.db = db;
        v.ga = ga; v.gb = gb; v.sl = sl; v.ou = ou; v.ov = ov;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic exp_a, prev_a;

        tbl[0]  = mk(1, 1, 8'hA5, 8'h3C, 1, 0, 0, 8'h00, 0);
        tbl[1]  = mk(1, 1, 8'hA5, 8'h3C, 1, 0, 0, 8'hA5, 1);
        tbl[2]  = mk(0, 0, 8'hA5, 8'h3C, 0, 0, 0, 8'hA5, 1);
        tbl[3]  = mk(0, 0, 8'hA5, 8'h3C, 0, 0, 0, 8'hA5, 0);
        tbl[4]  = mk(0, 1, 8'hA5, 8'h3C, 0, 1, 1, 8'hA5, 0);
        tbl[5]  = mk(0, 1, 8'hA5, 8'h3C, 0, 1, 1, 8'h3C, 1);
        tbl[6]  = mk(0, 1, 8'hA5, 8'h3C, 0, 1, 1, 8'h3C, 1);
        tbl[7]  = mk(0, 1, 8'hA5, 8'h3C, 0, 1, 1, 8'h3C, 1);
        tbl[8]  = mk(0, 1, 8'hA5, 8'h3C, 0, 1, 1, 8'h3C, 1);
        tbl[9]  = mk(0, 0, 8'hA5, 8'h3C, 0, 0, 1, 8'h3C, 1);
        tbl[10] = mk(0, 0, 8'hA5, 8'h3C, 0, 0, 1, 8'h3C, 0);
        tbl[11] = mk(1, 0, 8'h5A, 8'h3C, 1, 0, 0, 8'h3C, 0);
        tbl[12] = mk(1, 0, 8'h5A, 8'h3C, 1, 0, 0, 8'h5A, 1);
        tbl[13] = mk(0, 1, 8'h5A, 8'hC3, 0, 1, 1, 8'h5A, 1);
        tbl[14] = mk(0, 1, 8'h5A, 8'hC3, 0, 1, 1, 8'hC3, 1);
        tbl[15] = mk(1, 0, 8'h5A, 8'hC3, 1, 0, 0, 8'hC3, 1);
        tbl[16] = mk(0, 0, 8'h5A, 8'hC3, 0, 0, 0, 8'h5A, 1);
        tbl[17] = mk(0, 0, 8'h5A, 8'hC3, 0, 0, 0, 8'h5A, 0);
`ifdef MUX_ARB_FIXED_PRIO_EN
        tbl[18] = mk(1, 1, 8'h5A, 8'hC3, 1, 0, 0, 8'h5A, 0);
        tbl[19] = mk(0, 0, 8'h5A, 8'hC3, 0, 0, 0, 8'h5A, 1);
        tbl[20] = mk(0, 0, 8'h5A, 8'hC3, 0, 0, 0, 8'h5A, 0);
`else
        tbl[18] = mk(1, 1, 8'h5A, 8'hC3, 0, 1, 1, 8'h5A, 0);
        tbl[19] = mk(0, 0, 8'h5A, 8'hC3, 0, 0, 1, 8'hC3, 1);
        tbl[20] = mk(0, 0, 8'h5A, 8'hC3, 0, 0, 1, 8'hC3, 0);
`endif

        rst_n   = 1'b0;
        req_a   = 1'b1;
        req_b   = 1'b1;
        data_a  = 8'hA5;
        data_b  = 8'h3C;
        req_a1  = 1'b0;
        req_b1  = 1'b0;
        data_a1 = 8'hAA;
        data_b1 = 8'hBB;

        #1;
        chk("reset_t0", {20'd0, gnt_a, gnt_b, sel, out_valid, out}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("reset_cyc%0d", i), {20'd0, gnt_a, gnt_b, sel, out_valid, out}, 32'd0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            req_a  = tbl[i].ra;
            req_b  = tbl[i].rb;
            data_a = tbl[i].da;
            data_b = tbl[i].db;
            step();
            chk($sformatf("vec%0d", i), {20'd0, gnt_a, gnt_b, sel, out, out_valid},
                {20'd0, tbl[i].ga, tbl[i].gb, tbl[i].sl, tbl[i].ou, tbl[i].ov});
        end

        // Sustained contention: 8-cycle turns in round-robin, A forever with fixed priority.
        req_a  = 1'b1;
        req_b  = 1'b1;
        data_a = 8'h11;
        data_b = 8'h22;
        prev_a = 1'b1;
        for (int k = 1; k <= 28; k++) begin
            step();
`ifdef MUX_ARB_FIXED_PRIO_EN
            exp_a = 1'b1;
`else
            exp_a = (((k - 1) / 8) % 2) == 0;
`endif
            chk($sformatf("contend_gnt%0d", k), {30'd0, gnt_a, gnt_b}, {30'd0, exp_a, ~exp_a});
            if (k >= 2) begin
                chk($sformatf("contend_out%0d", k), {23'd0, out_valid, out},
                    {23'd0, 1'b1, (prev_a ? 8'h11 : 8'h22)});
            end
            prev_a = exp_a;
        end

        req_a = 1'b0;
        req_b = 1'b1;
        step();
        step();
        chk("own_b_pre", {22'd0, gnt_a, gnt_b, out_valid, out}, {22'd0, 1'b0, 1'b1, 1'b1, 8'h22});

        // Asynchronous reset mid-grant, well away from any clock edge.
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst", {20'd0, gnt_a, gnt_b, sel, out_valid, out}, 32'd0);
        req_a = 1'b0;
        req_b = 1'b0;
        step();
        chk("async_rst_hold", {20'd0, gnt_a, gnt_b, sel, out_valid, out}, 32'd0);
        rst_n = 1'b1;

        // MAX_HOLD=1: strict alternation while both request.
        req_a1 = 1'b1;
        req_b1 = 1'b1;
        prev_a = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
`ifdef MUX_ARB_FIXED_PRIO_EN
            exp_a = 1'b1;
`else
            exp_a = (k % 2) == 1;
`endif
            chk($sformatf("hold1_gnt%0d", k), {29'd0, gnt_a1, gnt_b1, sel1},
                {29'd0, exp_a, ~exp_a, ~exp_a});
            if (k >= 2) begin
                chk($sformatf("hold1_out%0d", k), {23'd0, out_valid1, out1},
                    {23'd0, 1'b1, (prev_a ? 8'hAA : 8'hBB)});
            end
            prev_a = exp_a;
        end
        chk("main_idle", {30'd0, gnt_a, gnt_b}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
